mem_stage: RTL
==============

# mem_stage

Memory-access pipeline stage of the veriRISCV core: the consumer of the EX stage's ex2mem_* pipeline register. It issues loads and stores on the data bus, formats load data, stalls the pipeline while a bus transaction is outstanding, and drives the mem2wb_* pipeline register into WB. Non-memory instructions pass the ALU result through with one cycle of latency.

## Interface
- No parameters. Widths come from `DATA_RANGE` (32 bits) and `RF_RANGE` (5 bits).
- clk  input  1  core clock; all flops on posedge.
- rst  input  1  asynchronous, active-high reset.
- ex2mem_reg_wen  input  1  destination register write enable.
- ex2mem_reg_waddr  input  5  destination register address.
- ex2mem_alu_out  input  32  ALU result; also the memory address.
- ex2mem_ill_instr  input  1  illegal-instruction flag.
- ex2mem_mem_read  input  1  instruction is a load.
- ex2mem_mem_write  input  1  instruction is a store.
- ex2mem_mem_size  input  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
- ex2mem_mem_unsigned  input  1  zero-extend load data (LBU/LHU).
- ex2mem_rs2_data  input  32  store data, already forwarded.
- dbus_req  output  1  request valid.
- dbus_write  output  1  1 = store, 0 = load.
- dbus_addr  output  32  word-aligned address, {alu_out[31:2],2'b00}.
- dbus_wdata  output  32  lane-replicated store data.
- dbus_byte_en  output  4  byte lane enables.
- dbus_ready  input  1  request accepted this cycle.
- dbus_rvalid  input  1  load response valid.
- dbus_rdata  input  32  load response data.
- mem_stall  output  1  freeze IF/ID/EX and hold ex2mem_* stable.
- mem2wb_reg_wen  output  1  WB register write enable.
- mem2wb_reg_waddr  output  5  WB register address.
- mem2wb_reg_wdata  output  32  WB register write data.
- mem2wb_ill_instr  output  1  illegal-instruction flag to WB.
- mem2wb_misalign  output  1  misaligned-access flag; see Configuration.

## Operation
- State machine has two states: IDLE and WAIT_RESP.
- Memory operation: mem_op = (mem_read | mem_write) & ~ill_instr & ~misaligned_trap.
- **IDLE, mem_op = 0:** no request, mem_stall = 0. The pass-through value is alu_out.
- **IDLE, mem_op = 1:** dbus_req = 1, driven combinationally from ex2mem_*.
  - Store with dbus_ready = 1: completes this cycle, mem_stall = 0.
  - Load with dbus_ready = 1: mem_stall = 1, next state WAIT_RESP.
  - dbus_ready = 0: mem_stall = 1, stay in IDLE with the request held stable.
- **WAIT_RESP:** dbus_req = 0, mem_stall = 1 until dbus_rvalid.
  - On dbus_rvalid: mem_stall = 0, capture the formatted load data, next state IDLE.
  - A dbus_rvalid seen in IDLE is ignored.
- **mem2wb update:** every cycle.
  - When mem_stall = 1, a bubble is inserted: wen = 0, ill = 0, misalign = 0.
  - Otherwise wen = reg_wen & ~ill & ~misalign_trap; waddr, ill and misalign are copied; wdata = load data or alu_out.
- **Store formatting:**
  - byte: wdata = {4{rs2[7:0]}}, byte_en = 0001 << addr[1:0].
  - half: wdata = {2{rs2[15:0]}}, byte_en = 0011 << {addr[1],1'b0}.
  - word: wdata = rs2, byte_en = 1111.
- **Load formatting:** byte lane is selected by addr[1:0], half lane by addr[1]. Sign-extend, or zero-extend when mem_unsigned = 1. Word loads pass through unchanged.
- **Illegal instruction:** suppresses the bus access and reg_wen. The flag itself propagates to WB.
- **Load-use hazards:** not handled here. EX's forward-from-MEM path carries alu_out only; the hazard unit prevents a load-use forward.

## Timing
- **Reset values:** all mem2wb_* outputs = 0, state = IDLE. dbus_req = 0 and mem_stall = 0 while rst = 1.
- **Non-memory instruction:** mem2wb_* is valid the cycle after ex2mem_*, with 0 stall cycles.
- **Store, ready in cycle 0:** 0 stall cycles; mem2wb_* is updated at the end of cycle 0.
- **Load, ready in cycle 0 and rvalid in cycle N:** mem_stall is high for cycles 0..N-1; mem2wb_reg_wdata is valid in cycle N+1.
- **Reset mid-transaction:** the FSM returns to IDLE asynchronously and the request is dropped. A late rvalid is discarded.
- **Back-to-back memory instructions:** the next request can be issued the cycle after the previous one completes.

## Configuration
- The macro is `CORE_MISALIGN_TRAP_EN`.
- A half access is misaligned when addr[0] = 1; a word access is misaligned when addr[1:0] != 0.
- **Defined:** a misaligned access issues no request, causes no stall, and forces wen = 0. mem2wb_misalign = 1 for that instruction.
- **Undefined:** mem2wb_misalign is tied to 0. The access proceeds with the offending low address bits ignored: word uses byte_en 1111, half uses addr[1] only.

## Structure
- The shared package `core.vh` holds the mem_size encodings (`CORE_MEM_BYTE`, `CORE_MEM_HALF`, `CORE_MEM_WORD`) and the FSM state encodings.
- One natural sub-module, `mem_load_format`, is purely combinational: it takes rdata, the address offset, size and unsigned, and produces the extended data. The store lane-replication logic stays in mem_stage.

## Test plan
- ALU passthrough: alu_out = 0x1234, wen = 1, waddr = 5 -> next cycle mem2wb_reg_wdata = 0x1234, waddr = 5, no stall.
- LB at 0x103, rdata = 0x80FF_FF00, ready immediately, rvalid one cycle later -> stall for 1 cycle, wdata = 0xFFFF_FF80. The same access as LBU -> 0x0000_0080.
- SH at 0x102 with rs2 = 0xABCD -> byte_en = 1100, wdata = 0xABCD_ABCD, addr = 0x100, no stall. Holding ready = 0 for 3 cycles -> 3 stall cycles with the request held stable.
- LW with rvalid delayed 4 cycles -> 4 stall cycles with mem2wb_reg_wen = 0 bubbles, then wdata = rdata.
- With `CORE_MISALIGN_TRAP_EN`: LW at 0x102 -> no dbus_req, mem2wb_misalign = 1, wen = 0. Without the macro -> a request at 0x100 with byte_en 1111.
- Assert rst while in WAIT_RESP, then rvalid -> state is IDLE, all outputs are 0, and the response is ignored. ill_instr = 1 on a store -> no dbus_req, mem2wb_ill_instr = 1.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the veriRISCV memory-access stage:
//   - datapath / register-file widths
//   - ex2mem_mem_size encodings (2'b11 is decoded as a word access)
//   - MEM stage FSM state encoding
//   - misalignment predicate (only used when CORE_MISALIGN_TRAP_EN is defined)
// -----------------------------------------------------------------------------
package mem_stage_pkg;

   localparam int DATA_W = 32;
   localparam int RF_W   = 5;

   localparam logic [1:0] CORE_MEM_BYTE = 2'b00;
   localparam logic [1:0] CORE_MEM_HALF = 2'b01;
   localparam logic [1:0] CORE_MEM_WORD = 2'b10;

   typedef enum logic {
      ST_IDLE      = 1'b0,
      ST_WAIT_RESP = 1'b1
   } mem_state_e;

   // Half needs a 2-byte aligned address, word (and the 2'b11 alias) a
   // 4-byte aligned one. Byte accesses can never be misaligned.
   function automatic logic is_misaligned(input logic [1:0] size,
                                          input logic [1:0] offset);
      logic mis;
      mis = 1'b0;
      if (size == CORE_MEM_HALF) begin
         mis = offset[0];
      end else if (size[1]) begin
         mis = (offset != 2'b00);
      end
      return mis;
   endfunction

endpackage

// File: rtl/mem_load_format.sv
// -----------------------------------------------------------------------------
// mem_load_format
// Purely combinational load-data formatter. Selects the addressed byte or
// half-word lane of the returned bus word and sign- or zero-extends it.
// Word accesses pass through unchanged.
// Ports:
//   rdata       in  32  raw data bus response word
//   offset      in  2   address bits [1:0] of the access
//   size        in  2   access size (byte / half / word)
//   is_unsigned in  1   zero-extend instead of sign-extend
//   ld_data     out 32  value to write back into the register file
// -----------------------------------------------------------------------------
module mem_load_format
   import mem_stage_pkg::*;
(
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        offset,
   input  logic [1:0]        size,
   input  logic              is_unsigned,
   output logic [DATA_W-1:0] ld_data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      case (offset)
         2'd0:    byte_lane = rdata[7:0];
         2'd1:    byte_lane = rdata[15:8];
         2'd2:    byte_lane = rdata[23:16];
         default: byte_lane = rdata[31:24];
      endcase

      // Only addr[1] picks the half lane; addr[0] is ignored here.
      half_lane = offset[1] ? rdata[31:16] : rdata[15:0];

      case (size)
         CORE_MEM_BYTE: ld_data = is_unsigned ? {24'd0, byte_lane}
                                              : {{24{byte_lane[7]}}, byte_lane};
         CORE_MEM_HALF: ld_data = is_unsigned ? {16'd0, half_lane}
                                              : {{16{half_lane[15]}}, half_lane};
         default:       ld_data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory-access pipeline stage. Consumes the ex2mem_* pipeline register,
// issues loads/stores on the data bus, stalls the front of the pipeline while
// a bus transaction is outstanding and drives the mem2wb_* register into WB.
// Non-memory instructions forward the ALU result with one cycle of latency.
//
// Optional feature: define CORE_MISALIGN_TRAP_EN to suppress misaligned
// half/word accesses and flag them on mem2wb_misalign. Without it, the
// offending low address bits are ignored and mem2wb_misalign stays 0.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   ex2mem_*              instruction from EX (held stable while mem_stall)
//   dbus_req/write/addr/wdata/byte_en   request side of the data bus
//   dbus_ready            request accepted this cycle
//   dbus_rvalid/rdata     load response
//   mem_stall             freeze IF/ID/EX
//   mem2wb_*              writeback pipeline register
// -----------------------------------------------------------------------------
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              ex2mem_reg_wen,
   input  logic [RF_W-1:0]   ex2mem_reg_waddr,
   input  logic [DATA_W-1:0] ex2mem_alu_out,
   input  logic              ex2mem_ill_instr,
   input  logic              ex2mem_mem_read,
   input  logic              ex2mem_mem_write,
   input  logic [1:0]        ex2mem_mem_size,
   input  logic              ex2mem_mem_unsigned,
   input  logic [DATA_W-1:0] ex2mem_rs2_data,
   output logic              dbus_req,
   output logic              dbus_write,
   output logic [DATA_W-1:0] dbus_addr,
   output logic [DATA_W-1:0] dbus_wdata,
   output logic [3:0]        dbus_byte_en,
   input  logic              dbus_ready,
   input  logic              dbus_rvalid,
   input  logic [DATA_W-1:0] dbus_rdata,
   output logic              mem_stall,
   output logic              mem2wb_reg_wen,
   output logic [RF_W-1:0]   mem2wb_reg_waddr,
   output logic [DATA_W-1:0] mem2wb_reg_wdata,
   output logic              mem2wb_ill_instr,
   output logic              mem2wb_misalign
);

   mem_state_e        state_q, state_d;
   logic              wen_q, wen_d;
   logic [RF_W-1:0]   waddr_q, waddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              ill_q, ill_d;
   logic              mis_q, mis_d;

   logic [1:0]        addr_off;
   logic              misalign_trap;
   logic              mem_op;
   logic              req;
   logic              stall;
   logic              load_done;
   logic [DATA_W-1:0] load_data;

   assign addr_off = ex2mem_alu_out[1:0];

`ifdef CORE_MISALIGN_TRAP_EN
   assign misalign_trap = (ex2mem_mem_read | ex2mem_mem_write)
                        & is_misaligned(ex2mem_mem_size, addr_off);
`else
   assign misalign_trap = 1'b0;
`endif

   assign mem_op = (ex2mem_mem_read | ex2mem_mem_write)
                 & ~ex2mem_ill_instr & ~misalign_trap;

   mem_load_format u_load_format (
      .rdata       (dbus_rdata),
      .offset      (addr_off),
      .size        (ex2mem_mem_size),
      .is_unsigned (ex2mem_mem_unsigned),
      .ld_data     (load_data)
   );

   // Bus handshake and stall generation. The request is driven straight from
   // ex2mem_*; since EX is frozen while stalled, the request stays stable
   // until dbus_ready is seen.
   always_comb begin
      state_d   = state_q;
      req       = 1'b0;
      stall     = 1'b0;
      load_done = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (mem_op) begin
               req = 1'b1;
               if (!dbus_ready) begin
                  stall = 1'b1;
               end else if (ex2mem_mem_read) begin
                  stall   = 1'b1;
                  state_d = ST_WAIT_RESP;
               end
            end
         end
         ST_WAIT_RESP: begin
            if (dbus_rvalid) begin
               load_done = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               stall = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Outputs go quiet immediately on reset, not at the next edge.
      if (rst) begin
         req   = 1'b0;
         stall = 1'b0;
      end
   end

   assign dbus_req   = req;
   assign dbus_write = ex2mem_mem_write & ~ex2mem_mem_read;
   assign dbus_addr  = {ex2mem_alu_out[DATA_W-1:2], 2'b00};
   assign mem_stall  = stall;

   // Store lane replication: every lane carries the data so the slave only
   // needs byte_en to place it.
   always_comb begin
      case (ex2mem_mem_size)
         CORE_MEM_BYTE: begin
            dbus_wdata   = {4{ex2mem_rs2_data[7:0]}};
            dbus_byte_en = 4'b0001 << addr_off;
         end
         CORE_MEM_HALF: begin
            dbus_wdata   = {2{ex2mem_rs2_data[15:0]}};
            dbus_byte_en = 4'b0011 << {addr_off[1], 1'b0};
         end
         default: begin
            dbus_wdata   = ex2mem_rs2_data;
            dbus_byte_en = 4'b1111;
         end
      endcase
   end

   // Writeback register: a stall inserts a bubble; address/data are held.
   always_comb begin
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      if (stall) begin
         wen_d = 1'b0;
         ill_d = 1'b0;
         mis_d = 1'b0;
      end else begin
         wen_d   = ex2mem_reg_wen & ~ex2mem_ill_instr & ~misalign_trap;
         waddr_d = ex2mem_reg_waddr;
         wdata_d = load_done ? load_data : ex2mem_alu_out;
         ill_d   = ex2mem_ill_instr;
         mis_d   = misalign_trap;
      end
   end

   // ---- MEM -> WB register boundary ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         wen_q   <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         ill_q   <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wen_q   <= wen_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         ill_q   <= ill_d;
         mis_q   <= mis_d;
      end
   end

   assign mem2wb_reg_wen   = wen_q;
   assign mem2wb_reg_waddr = waddr_q;
   assign mem2wb_reg_wdata = wdata_q;
   assign mem2wb_ill_instr = ill_q;
`ifdef CORE_MISALIGN_TRAP_EN
   assign mem2wb_misalign  = mis_q;
`else
   assign mem2wb_misalign  = 1'b0;
`endif

endmodule
